instr_mem_ctrl: RTL and testbench
=================================

INSTR_MEM_CTRL -- requirements
Module: instr_mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_SIZE, default 32768, RAM bytes total.
REQ-002 SHALL have parameter NUM_BANKS, default 2, RAM banks; power of two, 1..8.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-004 SHALL have parameter RD_LATENCY, default 1, cycles from grant to response; 1..4.
REQ-005 SHALL have parameter ADDR_WIDTH, default $clog2(RAM_SIZE)+1, byte address width; MSB selects boot ROM.
REQ-006 SHALL have port clk  input  1  clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_i  input  1  request valid.
REQ-009 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-010 SHALL have port addr_i  input  ADDR_WIDTH  byte address.
REQ-011 SHALL have port we_i  input  1  write when 1.
REQ-012 SHALL have port be_i  input  DATA_WIDTH/8  byte enables.
REQ-013 SHALL have port wdata_i  input  DATA_WIDTH  write data.
REQ-014 SHALL have port bypass_en_i  input  1  forwarded to every RAM bank.
REQ-015 SHALL have port rvalid_o  output  1  response valid.
REQ-016 SHALL have port rready_i  input  1  response consumed when rvalid_o&rready_i.
REQ-017 SHALL have port rdata_o  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-018 SHALL have port err_o  output  1  response error flag, valid with rvalid_o.

Function
REQ-019 SHALL instantiate NUM_BANKS sp_ram_wrap0 of RAM_SIZE/NUM_BANKS bytes and one boot_rom_wrap0; memory read latency 1 cycle.
REQ-020 SHALL word-interleave banks: bank = addr_i[2 +: log2(NUM_BANKS)], bank word = remaining RAM address bits.
REQ-021 SHALL assert gnt_o = req_i & (outstanding < RD_LATENCY+1); outstanding = in-flight + queued responses.
REQ-022 SHALL enable exactly one memory on a granted access; none when not granted.
REQ-023 SHALL return one response per grant, in order, first visible exactly RD_LATENCY cycles after grant when queue empty and rready_i high.
REQ-024 SHALL pipeline bank/ROM select tag and err through RD_LATENCY-1 register stages after the memory, then into a response FIFO of depth RD_LATENCY+1.
REQ-025 SHALL never drop a response: grant throttling guarantees FIFO cannot overflow with rready_i held low indefinitely.
REQ-026 SHALL treat a write to the ROM region (addr_i MSB=1) as error: no memory enabled, err_o=1, rdata_o=0.
REQ-027 SHALL complete RAM writes per be_i with err_o=0, rdata_o=0.
REQ-028 SHALL allow grant and response pop in the same cycle; outstanding unchanged.
REQ-029 SHALL hold rvalid_o, rdata_o, err_o stable while rvalid_o=1 and rready_i=0.

Reset
REQ-030 SHALL on rst_n low: gnt_o combinational from empty state, rvalid_o=0, err_o=0, rdata_o=0, FIFO and pipeline empty, outstanding=0.
REQ-031 SHALL discard all in-flight and queued responses on reset mid-operation; no response emitted after release for pre-reset grants.

Configuration
REQ-032 SHALL, with INSTR_MEM_WRITE_LOCK_EN defined, add port lock_i input 1; RAM writes while lock_i=1 are suppressed and respond err_o=1, rdata_o=0.
REQ-033 SHALL, without INSTR_MEM_WRITE_LOCK_EN, omit lock_i; RAM writes always performed.

Verification
REQ-034 SHALL cover: RD_LATENCY=1, write 0xDEADBEEF at 0x0010 then read 0x0010, rready_i=1 -> read response rdata_o=0xDEADBEEF, err_o=0, 1 cycle after grant.
REQ-035 SHALL cover: NUM_BANKS=4, writes to 0x0,0x4,0x8,0xC with distinct data, back-to-back reads -> 4 in-order responses, one per cycle, correct data.
REQ-036 SHALL cover: RD_LATENCY=3, rready_i=0, req_i held high -> exactly 4 grants, gnt_o low thereafter; raise rready_i -> 4 responses, grants resume.
REQ-037 SHALL cover: write to ROM address (MSB=1) -> err_o=1, rdata_o=0; following ROM read returns boot ROM word 0.
REQ-038 SHALL cover: rst_n pulsed low with 2 responses queued -> rvalid_o=0 after release, no stale response.
REQ-039 SHALL cover: INSTR_MEM_WRITE_LOCK_EN defined, lock_i=1, write 0x12345678 to 0x0020 -> err_o=1; read 0x0020 returns prior value.

Source files
------------

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: word-interleaved SRAM banks plus a boot ROM with in-order responses.
// Optional macro INSTR_MEM_WRITE_LOCK_EN adds lock_i, which suppresses RAM writes.

module sp_ram_wrap0 #(
   parameter int WORDS      = 4096,
   parameter int DATA_WIDTH = 32,
   parameter int AW         = 12
) (
   input  logic                    clk,
   input  logic                    en_i,
   input  logic                    we_i,
   input  logic [AW-1:0]           addr_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic                    bypass_en_i,
   output logic [DATA_WIDTH-1:0]   rdata_o
);
   logic [DATA_WIDTH-1:0] mem_q [WORDS];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Byte-masked write; registered read, bypass returns the write bus instead of the array.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
               if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end else if (bypass_en_i) begin
            rdata_q <= wdata_i;
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;
endmodule

module boot_rom_wrap0 #(
   parameter int AW         = 13,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic [AW-1:0]         addr_i,
   output logic [DATA_WIDTH-1:0] rdata_o
);
   logic [DATA_WIDTH-1:0] rdata_q;

   // Fixed image: upper half marks the ROM, lower half carries the word index.
   function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [AW-1:0] a);
      logic [31:0] w;
      w = 32'hB007_0000 | 32'(a);
      return DATA_WIDTH'(w);
   endfunction

   // Registered ROM read.
   always_ff @(posedge clk) begin
      if (en_i) rdata_q <= rom_word(addr_i);
   end

   assign rdata_o = rdata_q;
endmodule

module instr_mem_ctrl #(
   parameter int RAM_SIZE   = 32768,
   parameter int NUM_BANKS  = 2,
   parameter int DATA_WIDTH = 32,
   parameter int RD_LATENCY = 1,
   parameter int ADDR_WIDTH = $clog2(RAM_SIZE) + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    req_i,
   output logic                    gnt_o,
   input  logic [ADDR_WIDTH-1:0]   addr_i,
   input  logic                    we_i,
   input  logic [DATA_WIDTH/8-1:0] be_i,
   input  logic [DATA_WIDTH-1:0]   wdata_i,
   input  logic                    bypass_en_i,
`ifdef INSTR_MEM_WRITE_LOCK_EN
   input  logic                    lock_i,
`endif
   output logic                    rvalid_o,
   input  logic                    rready_i,
   output logic [DATA_WIDTH-1:0]   rdata_o,
   output logic                    err_o
);
   localparam int RAM_AW     = ADDR_WIDTH - 1;
   localparam int BANK_BITS  = $clog2(NUM_BANKS);
   localparam int BANK_W     = (BANK_BITS > 0) ? BANK_BITS : 1;
   localparam int BANK_WORDS = RAM_SIZE / NUM_BANKS / 4;
   localparam int BWA        = $clog2(BANK_WORDS);
   localparam int ROM_AW     = ADDR_WIDTH - 3;
   localparam int FD         = RD_LATENCY + 1;
   localparam int PW         = $clog2(FD);
   localparam int OW         = $clog2(FD + 1);
   localparam logic [OW-1:0] OUT_MAX = OW'(FD);

   logic                  is_rom_s, lock_s, wr_err_s;
   logic [RAM_AW-1:0]     ram_off_s;
   logic [BANK_W-1:0]     bank_s;
   logic [BWA-1:0]        bank_word_s;
   logic [NUM_BANKS-1:0]  ram_en_s;
   logic                  rom_en_s;
   logic [DATA_WIDTH-1:0] bank_rdata_s [NUM_BANKS];
   logic [DATA_WIDTH-1:0] rom_rdata_s;

   logic                  s0_v_q, s0_rd_q, s0_rom_q, s0_err_q;
   logic [BANK_W-1:0]     s0_bank_q;
   logic [DATA_WIDTH-1:0] s0_data_s;
   logic                  fin_v_s, fin_err_s;
   logic [DATA_WIDTH-1:0] fin_data_s;

   logic [DATA_WIDTH-1:0] fifo_d_q [FD];
   logic                  fifo_e_q [FD];
   logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
   logic [OW-1:0]         cnt_q, cnt_d, out_q, out_d;
   logic                  fifo_empty_s, push_s, fpop_s, resp_pop_s;

`ifdef INSTR_MEM_WRITE_LOCK_EN
   assign lock_s = lock_i;
`else
   assign lock_s = 1'b0;
`endif

   assign is_rom_s    = addr_i[ADDR_WIDTH-1];
   assign ram_off_s   = addr_i[RAM_AW-1:0];
   assign bank_s      = BANK_W'((ram_off_s >> 2) & RAM_AW'(NUM_BANKS - 1));
   assign bank_word_s = BWA'(ram_off_s >> (2 + BANK_BITS));
   assign wr_err_s    = we_i & (is_rom_s | lock_s);
   assign gnt_o       = req_i & (out_q < OUT_MAX);

   // Route a granted access to exactly one memory; erroring writes touch none.
   always_comb begin
      ram_en_s = '0;
      rom_en_s = 1'b0;
      if (gnt_o && !is_rom_s && !(we_i && lock_s)) begin
         ram_en_s[bank_s] = 1'b1;
      end else if (gnt_o && is_rom_s && !we_i) begin
         rom_en_s = 1'b1;
      end else begin
         ram_en_s = '0;
      end
   end

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      sp_ram_wrap0 #(.WORDS(BANK_WORDS), .DATA_WIDTH(DATA_WIDTH), .AW(BWA)) u_ram (
         .clk        (clk),
         .en_i       (ram_en_s[g]),
         .we_i       (we_i),
         .addr_i     (bank_word_s),
         .be_i       (be_i),
         .wdata_i    (wdata_i),
         .bypass_en_i(bypass_en_i),
         .rdata_o    (bank_rdata_s[g])
      );
   end

   boot_rom_wrap0 #(.AW(ROM_AW), .DATA_WIDTH(DATA_WIDTH)) u_rom (
      .clk    (clk),
      .en_i   (rom_en_s),
      .addr_i (addr_i[ADDR_WIDTH-2:2]),
      .rdata_o(rom_rdata_s)
   );

   // Tag travelling alongside the memory access cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_v_q    <= 1'b0;
         s0_rd_q   <= 1'b0;
         s0_rom_q  <= 1'b0;
         s0_err_q  <= 1'b0;
         s0_bank_q <= '0;
      end else begin
         s0_v_q    <= gnt_o;
         s0_rd_q   <= gnt_o & ~we_i;
         s0_rom_q  <= is_rom_s;
         s0_err_q  <= gnt_o & wr_err_s;
         s0_bank_q <= bank_s;
      end
   end

   // Writes and errors carry zero data.
   always_comb begin
      s0_data_s = '0;
      if (s0_rd_q && s0_rom_q) begin
         s0_data_s = rom_rdata_s;
      end else if (s0_rd_q) begin
         s0_data_s = bank_rdata_s[s0_bank_q];
      end else begin
         s0_data_s = '0;
      end
   end

   if (RD_LATENCY == 1) begin : g_lat1
      assign fin_v_s    = s0_v_q;
      assign fin_err_s  = s0_err_q;
      assign fin_data_s = s0_data_s;
   end else begin : g_pipe
      logic                  p_v_q [RD_LATENCY-1];
      logic                  p_e_q [RD_LATENCY-1];
      logic [DATA_WIDTH-1:0] p_d_q [RD_LATENCY-1];

      // Delay stages so each response lands RD_LATENCY cycles after its grant.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < RD_LATENCY-1; k++) begin
               p_v_q[k] <= 1'b0;
               p_e_q[k] <= 1'b0;
               p_d_q[k] <= '0;
            end
         end else begin
            p_v_q[0] <= s0_v_q;
            p_e_q[0] <= s0_err_q;
            p_d_q[0] <= s0_data_s;
            for (int k = 1; k < RD_LATENCY-1; k++) begin
               p_v_q[k] <= p_v_q[k-1];
               p_e_q[k] <= p_e_q[k-1];
               p_d_q[k] <= p_d_q[k-1];
            end
         end
      end

      assign fin_v_s    = p_v_q[RD_LATENCY-2];
      assign fin_err_s  = p_e_q[RD_LATENCY-2];
      assign fin_data_s = p_d_q[RD_LATENCY-2];
   end

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(FD - 1)) return '0;
      else return p + PW'(1);
   endfunction

   assign fifo_empty_s = (cnt_q == '0);
   assign fpop_s       = ~fifo_empty_s & rready_i;
   assign push_s       = fin_v_s & ~(fifo_empty_s & rready_i);
   assign resp_pop_s   = rvalid_o & rready_i;

   // Queue head wins; with nothing queued the pipeline result falls through.
   always_comb begin
      rvalid_o = 1'b0;
      rdata_o  = '0;
      err_o    = 1'b0;
      if (!fifo_empty_s) begin
         rvalid_o = 1'b1;
         rdata_o  = fifo_d_q[rd_q];
         err_o    = fifo_e_q[rd_q];
      end else if (fin_v_s) begin
         rvalid_o = 1'b1;
         rdata_o  = fin_data_s;
         err_o    = fin_err_s;
      end else begin
         rvalid_o = 1'b0;
      end
   end

   // Next-state for pointers, occupancy and outstanding count.
   always_comb begin
      wr_d  = push_s ? ptr_inc(wr_q) : wr_q;
      rd_d  = fpop_s ? ptr_inc(rd_q) : rd_q;
      cnt_d = cnt_q;
      out_d = out_q;
      if (push_s && !fpop_s) begin
         cnt_d = cnt_q + OW'(1);
      end else if (fpop_s && !push_s) begin
         cnt_d = cnt_q - OW'(1);
      end else begin
         cnt_d = cnt_q;
      end
      if (gnt_o && !resp_pop_s) begin
         out_d = out_q + OW'(1);
      end else if (resp_pop_s && !gnt_o) begin
         out_d = out_q - OW'(1);
      end else begin
         out_d = out_q;
      end
   end

   // Control state; reset drops every in-flight and queued response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         out_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         out_q <= out_d;
      end
   end

   // Response storage.
   always_ff @(posedge clk) begin
      if (push_s) begin
         fifo_d_q[wr_q] <= fin_data_s;
         fifo_e_q[wr_q] <= fin_err_s;
      end
   end
endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Bench for instr_mem_ctrl: two instances (latency 1 / 2 banks, latency 3 / 4 banks) checked
// every cycle against a flat byte-memory and response-queue model, plus literal spot checks.
module tb_instr_mem_ctrl;
`ifdef INSTR_MEM_WRITE_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        byp = 1'b0;
   logic        req [2], gnt [2], we [2], rv [2], rr [2], er [2], lk [2];
   logic [15:0] addr [2];
   logic [3:0]  be [2];
   logic [31:0] wd [2], rd [2];

   always #5 clk = ~clk;

   instr_mem_ctrl #(.NUM_BANKS(2), .RD_LATENCY(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .req_i(req[0]), .gnt_o(gnt[0]), .addr_i(addr[0]),
      .we_i(we[0]), .be_i(be[0]), .wdata_i(wd[0]), .bypass_en_i(byp),
`ifdef INSTR_MEM_WRITE_LOCK_EN
      .lock_i(lk[0]),
`endif
      .rvalid_o(rv[0]), .rready_i(rr[0]), .rdata_o(rd[0]), .err_o(er[0]));

   instr_mem_ctrl #(.NUM_BANKS(4), .RD_LATENCY(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .req_i(req[1]), .gnt_o(gnt[1]), .addr_i(addr[1]),
      .we_i(we[1]), .be_i(be[1]), .wdata_i(wd[1]), .bypass_en_i(byp),
`ifdef INSTR_MEM_WRITE_LOCK_EN
      .lock_i(lk[1]),
`endif
      .rvalid_o(rv[1]), .rready_i(rr[1]), .rdata_o(rd[1]), .err_o(er[1]));

   typedef struct { logic [31:0] data; logic err; int ready; } exp_t;
   exp_t        q0[$], q1[$];
   logic [7:0]  mm [int];
   int          last_pop [2];
   int          rl [2];
   int          cyc = 0;
   int          n_cmp = 0, n_bad = 0;
   int          g_last, col_n;
   logic [31:0] col_d [8];
   logic        col_e [8];
   int          col_c [8];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, i, cyc, act, exp);
      end
   endtask

   // Model: what one granted access must eventually return.
   task automatic model_access(input int i, output exp_t r);
      logic [15:0] a;
      int          base;
      a = addr[i];
      base = i * 65536 + (int'(a[14:0]) & ~3);
      r.data = 32'h0;
      r.err = 1'b0;
      r.ready = cyc + rl[i];
      if (we[i]) begin
         if (a[15] || (LOCK_EN && lk[i])) r.err = 1'b1;
         else
            for (int b = 0; b < 4; b++)
               if (be[i][b]) mm[base + b] = wd[i][8*b +: 8];
      end else if (a[15]) begin
         r.data = 32'hB007_0000 | 32'(a[14:2]);
      end else begin
         for (int b = 0; b < 4; b++)
            r.data[8*b +: 8] = mm.exists(base + b) ? mm[base + b] : 8'hxx;
      end
   endtask

   task automatic check_inst(input int i);
      exp_t h, r;
      int   n, vis;
      bit   eg, ev;
      if (!rst_n) begin
         if (i == 0) q0.delete(); else q1.delete();
         last_pop[i] = -100;
         chk("rst_rvalid", i, 32'(rv[i]), 32'h0);
         chk("rst_rdata", i, rd[i], 32'h0);
         chk("rst_err", i, 32'(er[i]), 32'h0);
         chk("rst_gnt", i, 32'(gnt[i]), 32'(req[i]));
      end else begin
         n = (i == 0) ? q0.size() : q1.size();
         eg = req[i] && (n < rl[i] + 1);
         chk("gnt", i, 32'(gnt[i]), 32'(eg));
         ev = 1'b0;
         if (n > 0) begin
            h = (i == 0) ? q0[0] : q1[0];
            vis = (h.ready > last_pop[i] + 1) ? h.ready : last_pop[i] + 1;
            ev = (cyc >= vis);
         end
         chk("rvalid", i, 32'(rv[i]), 32'(ev));
         if (ev) begin
            chk("rdata", i, rd[i], h.data);
            chk("err", i, 32'(er[i]), 32'(h.err));
            if (rr[i]) begin
               if (i == 0) r = q0.pop_front(); else r = q1.pop_front();
               last_pop[i] = cyc;
            end
         end
         if (eg) begin
            model_access(i, r);
            if (i == 0) q0.push_back(r); else q1.push_back(r);
         end
      end
   endtask

   // Single compare process: both instances, every cycle.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) check_inst(i);
   end

   task automatic do_op(input int i, input logic w, input logic [15:0] a, input logic [3:0] b,
                        input logic [31:0] d, output int gc);
      req[i] = 1'b1; we[i] = w; addr[i] = a; be[i] = b; wd[i] = d;
      gc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (gnt[i]) begin
            gc = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      req[i] = 1'b0;
      if (gc < 0) chk("grant_timeout", i, 32'h0, 32'h1);
   endtask

   task automatic collect(input int i, input int n, input int maxc);
      col_n = 0;
      for (int k = 0; k < maxc && col_n < n; k++) begin
         @(negedge clk);
         if (rv[i] && rr[i]) begin
            col_d[col_n] = rd[i];
            col_e[col_n] = er[i];
            col_c[col_n] = cyc;
            col_n++;
         end
      end
      chk("resp_count", i, 32'(col_n), 32'(n));
   endtask

   task automatic op1(input int i, input logic w, input logic [15:0] a, input logic [3:0] b,
                      input logic [31:0] d);
      fork
         do_op(i, w, a, b, d, g_last);
         collect(i, 1, 30);
      join
      @(posedge clk); #1;
   endtask

   task automatic wait_idle(input int i);
      bit done;
      done = 1'b0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         done = ((i == 0) ? q0.size() : q1.size()) == 0;
      end
      if (!done) chk("drain_timeout", i, 32'h0, 32'h1);
      @(posedge clk); #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] wdat [4];
      int          g0, gt, gcnt, pcnt;
      wdat = '{32'hC0DE_0000, 32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
      rl[0] = 1; rl[1] = 3;
      last_pop[0] = -100; last_pop[1] = -100;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; we[i] = 1'b0; addr[i] = 16'h0; be[i] = 4'h0;
         wd[i] = 32'h0; rr[i] = 1'b1; lk[i] = 1'b0;
      end
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Latency-1 write then read.
      op1(0, 1'b1, 16'h0010, 4'hF, 32'hDEAD_BEEF);
      chk("wr_err", 0, 32'(col_e[0]), 32'h0);
      chk("wr_rdata", 0, col_d[0], 32'h0);
      op1(0, 1'b0, 16'h0010, 4'hF, 32'h0);
      chk("rd_latency", 0, 32'(col_c[0] - g_last), 32'd1);
      chk("rd_data", 0, col_d[0], 32'hDEAD_BEEF);
      chk("rd_err", 0, 32'(col_e[0]), 32'h0);

      // Partial byte-enable write.
      op1(0, 1'b1, 16'h0040, 4'hF, 32'h1122_3344);
      op1(0, 1'b1, 16'h0040, 4'h3, 32'hAABB_CCDD);
      op1(0, 1'b0, 16'h0040, 4'hF, 32'h0);
      chk("be_merge", 0, col_d[0], 32'h1122_CCDD);

      // ROM write error, then ROM reads.
      op1(0, 1'b1, 16'h8000, 4'hF, 32'hFFFF_FFFF);
      chk("rom_wr_err", 0, 32'(col_e[0]), 32'h1);
      chk("rom_wr_data", 0, col_d[0], 32'h0);
      op1(0, 1'b0, 16'h8000, 4'hF, 32'h0);
      chk("rom_word0", 0, col_d[0], 32'hB007_0000);
      op1(0, 1'b0, 16'h8008, 4'hF, 32'h0);

      // Two responses queued, then reset.
      rr[0] = 1'b0;
      do_op(0, 1'b0, 16'h0010, 4'hF, 32'h0, gt);
      do_op(0, 1'b0, 16'h0040, 4'hF, 32'h0, gt);
      @(negedge clk);
      chk("queued_valid", 0, 32'(rv[0]), 32'h1);
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rr[0] = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("no_stale", 0, 32'(rv[0]), 32'h0);
      end
      @(posedge clk); #1;
      op1(0, 1'b0, 16'h0010, 4'hF, 32'h0);
      chk("post_rst_rd", 0, col_d[0], 32'hDEAD_BEEF);

`ifdef INSTR_MEM_WRITE_LOCK_EN
      op1(0, 1'b1, 16'h0020, 4'hF, 32'hCAFE_F00D);
      lk[0] = 1'b1;
      op1(0, 1'b1, 16'h0020, 4'hF, 32'h1234_5678);
      chk("lock_err", 0, 32'(col_e[0]), 32'h1);
      chk("lock_data", 0, col_d[0], 32'h0);
      lk[0] = 1'b0;
      op1(0, 1'b0, 16'h0020, 4'hF, 32'h0);
      chk("lock_keep", 0, col_d[0], 32'hCAFE_F00D);
`endif

      // Four banks: one word per bank, then back-to-back reads.
      for (int k = 0; k < 4; k++) op1(1, 1'b1, 16'(k * 4), 4'hF, wdat[k]);
      wait_idle(1);
      g0 = -1;
      fork
         begin
            for (int k = 0; k < 4; k++) begin
               do_op(1, 1'b0, 16'(k * 4), 4'hF, 32'h0, gt);
               if (k == 0) g0 = gt;
            end
         end
         collect(1, 4, 40);
      join
      @(posedge clk); #1;
      chk("b2b_latency", 1, 32'(col_c[0] - g0), 32'd3);
      chk("b2b_d0", 1, col_d[0], 32'hC0DE_0000);
      chk("b2b_d1", 1, col_d[1], 32'hC0DE_0001);
      chk("b2b_d2", 1, col_d[2], 32'hC0DE_0002);
      chk("b2b_d3", 1, col_d[3], 32'hC0DE_0003);
      chk("b2b_spacing", 1, 32'(col_c[3] - col_c[0]), 32'd3);

      // Throttling with rready low, then release.
      rr[1] = 1'b0;
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0004; be[1] = 4'hF;
      gcnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (gnt[1]) gcnt++;
      end
      chk("throttle_grants", 1, 32'(gcnt), 32'd4);
      @(posedge clk); #1 rr[1] = 1'b1;
      gcnt = 0; pcnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (gnt[1]) gcnt++;
         if (rv[1] && rr[1]) pcnt++;
      end
      chk("resume_grants", 1, 32'(gcnt > 0), 32'h1);
      chk("resume_pops", 1, 32'(pcnt >= 4), 32'h1);
      @(posedge clk); #1 req[1] = 1'b0;
      wait_idle(1);
      wait_idle(0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
